sa_load_sequencer: RTL and testbench

Sequences row loads into the systolic array on behalf of the tile scheduler. Accepts one tile command at a time and streams rows from a scratchpad source: weights first if requested, then inputs with matching partial sums. Drives the control unit's `input_en`/`weight_en`/`partial_en`/`row_en` load interface. Gates every load on array state: weights only into a drained array, inputs only when FIFO space is reported.

---
 rtl/sa_load_sequencer_if.sv | 42 ++++
 rtl/sa_load_sequencer.sv | 108 ++++++++++
 tb/tb_sa_load_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_load_sequencer_if.sv
// Bundle between the tile scheduler / control unit side and the load sequencer.
// A row or command transfers on a clock edge where both valid and ready are high; valid is never gated by ready.
interface sa_load_sequencer_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    localparam int RW = $clog2(N);

    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_load_weights;
    logic            src_valid;
    logic            src_ready;
    logic [N*DW-1:0] src_data;
    logic [N*DW-1:0] src_ps_data;
    logic            array_idle;
    logic            fifo_has_space;
    logic            input_en;
    logic            weight_en;
    logic            partial_en;
    logic [RW-1:0]   row_en;
    logic [N*DW-1:0] row_data;
    logic [N*DW-1:0] row_ps_data;
    logic            done;
    logic            stall_clr;
    logic [15:0]     stall_cnt;
    logic [2:0]      state_dbg;

    modport slave (
        input  cmd_valid, cmd_load_weights, src_valid, src_data, src_ps_data,
        input  array_idle, fifo_has_space, stall_clr,
        output cmd_ready, src_ready, input_en, weight_en, partial_en,
        output row_en, row_data, row_ps_data, done, stall_cnt, state_dbg
    );

    modport master (
        output cmd_valid, cmd_load_weights, src_valid, src_data, src_ps_data,
        output array_idle, fifo_has_space, stall_clr,
        input  cmd_ready, src_ready, input_en, weight_en, partial_en,
        input  row_en, row_data, row_ps_data, done, stall_cnt, state_dbg
    );
endinterface

// File: rtl/sa_load_sequencer.sv
// Streams one tile's weight rows (optional) and input/partial rows into the systolic array,
// rows N-1 down to 0, gating weights on a drained array and inputs on reported FIFO space.
module sa_load_sequencer #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input logic                clk,
    input logic                nRST,
    sa_load_sequencer_if.slave bus
);
    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] ROW_TOP = RW'(N - 1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDRAIN = 3'd1,
        S_WLOAD  = 3'd2,
        S_ISPACE = 3'd3,
        S_ILOAD  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] row_cnt;
    logic          hs;
    logic          last_row;
    logic          stall;

    assign hs       = bus.src_ready & bus.src_valid;
    assign last_row = (row_cnt == '0);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // WDRAIN and ISPACE are always entered for at least one cycle, even if their condition already holds.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (bus.cmd_valid) state_next = bus.cmd_load_weights ? S_WDRAIN : S_ISPACE;
            S_WDRAIN: if (bus.array_idle) state_next = S_WLOAD;
            S_WLOAD:  if (hs && last_row) state_next = S_ISPACE;
            S_ISPACE: if (bus.fifo_has_space) state_next = S_ILOAD;
            S_ILOAD:  if (hs && last_row) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.src_ready = (state == S_WLOAD) || (state == S_ILOAD);
        bus.state_dbg = state;
        stall         = 1'b0;
        unique case (state)
            S_WDRAIN: stall = !bus.array_idle;
            S_ISPACE: stall = !bus.fifo_has_space;
            S_WLOAD,
            S_ILOAD:  stall = !bus.src_valid;
            default:  stall = 1'b0;
        endcase
    end

    // Row counter re-arms to N-1 whenever no rows are being streamed, so a reset or phase change never replays.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            row_cnt         <= ROW_TOP;
            bus.input_en    <= 1'b0;
            bus.partial_en  <= 1'b0;
            bus.weight_en   <= 1'b0;
            bus.done        <= 1'b0;
            bus.row_en      <= '0;
            bus.row_data    <= '0;
            bus.row_ps_data <= '0;
        end else begin
            bus.input_en   <= hs && (state == S_ILOAD);
            bus.partial_en <= hs && (state == S_ILOAD);
            bus.weight_en  <= hs && (state == S_WLOAD);
            bus.done       <= hs && (state == S_ILOAD) && last_row;
            if (!bus.src_ready) begin
                row_cnt <= ROW_TOP;
            end else if (hs) begin
                row_cnt <= row_cnt - ROW_ONE;
            end
            if (hs) begin
                bus.row_en   <= row_cnt;
                bus.row_data <= bus.src_data;
            end
            if (hs && (state == S_ILOAD)) begin
                bus.row_ps_data <= bus.src_ps_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bus.stall_cnt <= '0;
        end else if (bus.stall_clr) begin
            bus.stall_cnt <= '0;
        end else if (stall && (bus.stall_cnt != 16'hFFFF)) begin
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_sa_load_sequencer.sv
// Bench for sa_load_sequencer: a vector table, directed corner sequences and random traffic,
// all checked against a step-queue model of each tile's progress.
module tb_sa_load_sequencer;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int W  = N * DW;
    localparam int RW = $clog2(N);

    localparam int K_DRAIN = 1;
    localparam int K_WROW  = 2;
    localparam int K_SPACE = 3;
    localparam int K_IROW  = 4;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    sa_load_sequencer_if #(.N(N), .DW(DW)) bus ();
    sa_load_sequencer #(.N(N), .DW(DW)) dut (.clk(clk), .nRST(nRST), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model: a tile is a queue of steps; the head step either completes this cycle or stalls.
    int              q[$];
    logic            m_ie, m_we, m_done;
    logic [RW-1:0]   m_row;
    logic [W-1:0]    m_data, m_ps;
    logic [15:0]     m_stall;

    typedef struct {
        logic          cv, lw, sv, ai, fs;
        logic          ie, we, dn, cr;
        logic [RW-1:0] row;
        logic [15:0]   st;
    } vec_t;
    vec_t vt[23];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rows_left(input int kind);
        int c = 0;
        foreach (q[i]) if (q[i] == kind) c++;
        return c;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ie = 0; m_we = 0; m_done = 0; m_row = '0;
        m_data = '0; m_ps = '0; m_stall = '0;
    endtask

    task automatic model_step();
        logic stall_c;
        int   head;
        int   idx;
        stall_c = 0;
        m_ie = 0; m_we = 0; m_done = 0;
        if (q.size() == 0) begin
            if (bus.cmd_valid) begin
                if (bus.cmd_load_weights) begin
                    q.push_back(K_DRAIN);
                    repeat (N) q.push_back(K_WROW);
                end
                q.push_back(K_SPACE);
                repeat (N) q.push_back(K_IROW);
            end
        end else begin
            head = q[0];
            case (head)
                K_DRAIN: if (bus.array_idle) void'(q.pop_front()); else stall_c = 1;
                K_SPACE: if (bus.fifo_has_space) void'(q.pop_front()); else stall_c = 1;
                default: begin
                    if (bus.src_valid) begin
                        void'(q.pop_front());
                        idx    = rows_left(head);
                        m_row  = idx[RW-1:0];
                        m_data = bus.src_data;
                        if (head == K_IROW) begin
                            m_ie   = 1;
                            m_ps   = bus.src_ps_data;
                            m_done = (idx == 0);
                        end else begin
                            m_we = 1;
                        end
                    end else begin
                        stall_c = 1;
                    end
                end
            endcase
        end
        if (bus.stall_clr) m_stall = '0;
        else if (stall_c && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    endtask

    task automatic check_all();
        logic exp_src_ready;
        exp_src_ready = (q.size() != 0) && (q[0] == K_WROW || q[0] == K_IROW);
        chk("cmd_ready", W'(bus.cmd_ready), W'(q.size() == 0));
        chk("src_ready", W'(bus.src_ready), W'(exp_src_ready));
        chk("input_en", W'(bus.input_en), W'(m_ie));
        chk("partial_en", W'(bus.partial_en), W'(m_ie));
        chk("weight_en", W'(bus.weight_en), W'(m_we));
        chk("done", W'(bus.done), W'(m_done));
        chk("stall_cnt", W'(bus.stall_cnt), W'(m_stall));
        chk("row_data", bus.row_data, m_data);
        if (m_ie || m_we) chk("row_en", W'(bus.row_en), W'(m_row));
        if (m_ie) chk("row_ps_data", bus.row_ps_data, m_ps);
    endtask

    task automatic cyc(input logic cv, input logic lw, input logic sv,
                       input logic ai, input logic fs, input logic sc);
        bus.cmd_valid        = cv;
        bus.cmd_load_weights = lw;
        bus.src_valid        = sv;
        bus.array_idle       = ai;
        bus.fifo_has_space   = fs;
        bus.stall_clr        = sc;
        bus.src_data         = {$urandom, $urandom};
        bus.src_ps_data      = {$urandom, $urandom};
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_cmd_ready"}, W'(bus.cmd_ready), W'(1));
        chk({tag, "_src_ready"}, W'(bus.src_ready), '0);
        chk({tag, "_strobes"}, W'({bus.input_en, bus.weight_en, bus.partial_en, bus.done}), '0);
        chk({tag, "_row_en"}, W'(bus.row_en), '0);
        chk({tag, "_row_data"}, bus.row_data, '0);
        chk({tag, "_row_ps_data"}, bus.row_ps_data, '0);
        chk({tag, "_stall_cnt"}, W'(bus.stall_cnt), '0);
    endtask

    task automatic put(input int i, input logic cv, input logic lw, input logic sv,
                       input logic ai, input logic fs, input logic ie, input logic we,
                       input logic dn, input logic cr, input int row, input int st);
        vt[i].cv = cv; vt[i].lw = lw; vt[i].sv = sv; vt[i].ai = ai; vt[i].fs = fs;
        vt[i].ie = ie; vt[i].we = we; vt[i].dn = dn; vt[i].cr = cr;
        vt[i].row = row[RW-1:0]; vt[i].st = st[15:0];
    endtask

    initial begin
        logic [15:0] s0;
        int          seen;

        nRST = 1'b0;
        bus.cmd_valid = 0; bus.cmd_load_weights = 0; bus.src_valid = 0;
        bus.array_idle = 0; bus.fifo_has_space = 0; bus.stall_clr = 0;
        bus.src_data = '0; bus.src_ps_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks("reset");
        check_all();
        nRST = 1'b1;

        // Plain tile, then a weight tile whose drain waits 5 cycles.
        put(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        put(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 5; i++) put(i, 0, 0, 1, 1, 1, 1, 0, i == 5, i == 5, 5 - i, 0);
        put(6, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
        put(7, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 8; i <= 12; i++) put(i, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, i - 7);
        put(13, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 5);
        for (int i = 14; i <= 17; i++) put(i, 0, 0, 1, 1, 1, 0, 1, 0, 0, 17 - i, 5);
        put(18, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 5);
        for (int i = 19; i <= 22; i++) put(i, 0, 0, 1, 1, 1, 1, 0, i == 22, i == 22, 22 - i, 5);

        for (int i = 0; i < 23; i++) begin
            cyc(vt[i].cv, vt[i].lw, vt[i].sv, vt[i].ai, vt[i].fs, 1'b0);
            chk("vec_input_en", W'(bus.input_en), W'(vt[i].ie));
            chk("vec_weight_en", W'(bus.weight_en), W'(vt[i].we));
            chk("vec_done", W'(bus.done), W'(vt[i].dn));
            chk("vec_cmd_ready", W'(bus.cmd_ready), W'(vt[i].cr));
            chk("vec_stall_cnt", W'(bus.stall_cnt), W'(vt[i].st));
            if (vt[i].ie || vt[i].we) chk("vec_row_en", W'(bus.row_en), W'(vt[i].row));
        end

        // Two-cycle source bubble between input rows 2 and 1.
        cyc(1, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        chk("bubble_row2", W'(bus.row_en), W'(2));
        s0 = bus.stall_cnt;
        cyc(0, 0, 0, 1, 1, 0);
        chk("bubble_gap0", W'(bus.input_en), '0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("bubble_gap1", W'(bus.input_en), '0);
        chk("bubble_stall", W'(bus.stall_cnt), W'(s0 + 16'd2));
        cyc(0, 0, 1, 1, 1, 0);
        chk("bubble_resume_en", W'(bus.input_en), W'(1));
        chk("bubble_resume_row", W'(bus.row_en), W'(1));
        cyc(0, 0, 1, 1, 1, 0);
        chk("bubble_done", W'(bus.done), W'(1));

        // Space waits 3 cycles, then drops during the load without effect.
        s0 = bus.stall_cnt;
        cyc(1, 0, 1, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        chk("space_no_early_load", W'(bus.input_en), '0);
        seen = 0;
        repeat (4) begin
            cyc(0, 0, 1, 1, 0, 0);
            if (bus.input_en) seen++;
        end
        chk("space_rows", W'(seen), W'(4));
        chk("space_done", W'(bus.done), W'(1));
        chk("space_stall", W'(bus.stall_cnt), W'(s0 + 16'd3));

        // Reset while input row 2 is on the outputs; next tile restarts at row 3.
        cyc(1, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        chk("pre_reset_row", W'(bus.row_en), W'(2));
        nRST = 1'b0;
        #1;
        model_reset();
        reset_checks("midreset");
        @(negedge clk);
        check_all();
        nRST = 1'b1;
        cyc(1, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        chk("restart_en", W'(bus.input_en), W'(1));
        chk("restart_row", W'(bus.row_en), W'(3));
        repeat (3) cyc(0, 0, 1, 1, 1, 0);

        // Saturation of the stall counter while the array stays busy, then clear beats increment.
        cyc(1, 1, 1, 0, 1, 0);
        repeat (70000) cyc(0, 0, 1, 0, 1, 0);
        chk("stall_saturated", W'(bus.stall_cnt), W'(16'hFFFF));
        cyc(0, 0, 1, 0, 1, 1);
        chk("stall_clear", W'(bus.stall_cnt), '0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("stall_after_clear", W'(bus.stall_cnt), W'(1));

        // Random traffic against the model.
        repeat (4000) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
            chk("excl_strobes", W'(bus.input_en & bus.weight_en), '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
